fetch_mem_if: RTL and testbench

- Instruction-memory request/response engine on the far side of the PC generator's valid/ready handshake.
- Accepts one PC per cycle from the PC generator and drives the ready that the generator sees as mem_ready_i.
- Issues the request to instruction memory and tracks in-flight requests. Responses made stale by a flush (mispredict or exception) are discarded.
- Surviving {pc, instr, except} entries are buffered in order toward decode.

---
 rtl/fetch_mem_if_pkg.sv | 37 +++
 rtl/fetch_mem_if_if.sv | 45 ++++
 rtl/fetch_mem_if_ifq.sv | 77 +++++++
 rtl/fetch_mem_if.sv | 144 ++++++++++++++
 tb/tb_fetch_mem_if.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_mem_if_pkg.sv
// ----------------------------------------------------------------------------
// fetch_mem_if_pkg
// Shared types and constants for the instruction-fetch memory interface.
//   XLEN            : address / PC width
//   ILEN            : instruction width
//   FETCH_BUF_DEPTH : default in-flight + buffered capacity
//   fetch_track_t   : tracker entry {pc, stale}
//   fetch_instr_t   : decode-bound entry {pc, instr, except}
// ----------------------------------------------------------------------------
package fetch_mem_if_pkg;

  localparam int XLEN            = 64;
  localparam int ILEN            = 32;
  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            stale;
  } fetch_track_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            except;
  } fetch_instr_t;

  function automatic fetch_instr_t fetch_make_entry(input logic [XLEN-1:0] pc,
                                                    input logic [ILEN-1:0] instr,
                                                    input logic            except);
    fetch_instr_t e;
    e.pc     = pc;
    e.instr  = instr;
    e.except = except;
    return e;
  endfunction

endpackage

// File: rtl/fetch_mem_if_if.sv
// ----------------------------------------------------------------------------
// fetch_mem_if_if
// Bundles the three handshakes around the fetch memory engine plus flush:
//   pcgen_* : PC generator -> engine (valid/ready)
//   mem_*   : engine <-> instruction memory (request and in-order answer)
//   instr_* : engine -> decode (valid/ready)
// Modports:
//   master : the fetch engine side
//   slave  : the environment (PC generator, memory, decode, flush source)
// ----------------------------------------------------------------------------
interface fetch_mem_if_if;
  import fetch_mem_if_pkg::*;

  logic            flush_i;
  logic            pcgen_valid_i;
  logic [XLEN-1:0] pcgen_pc_i;
  logic            pcgen_ready_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_ans_valid_i;
  logic [ILEN-1:0] mem_ans_data_i;
  logic            mem_ans_except_i;
  logic            mem_ans_ready_o;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_pc_o;
  logic [ILEN-1:0] instr_o;
  logic            instr_except_o;

  modport master (
    input  flush_i, pcgen_valid_i, pcgen_pc_i, mem_req_ready_i,
           mem_ans_valid_i, mem_ans_data_i, mem_ans_except_i, instr_ready_i,
    output pcgen_ready_o, mem_req_valid_o, mem_req_addr_o, mem_ans_ready_o,
           instr_valid_o, instr_pc_o, instr_o, instr_except_o
  );

  modport slave (
    output flush_i, pcgen_valid_i, pcgen_pc_i, mem_req_ready_i,
           mem_ans_valid_i, mem_ans_data_i, mem_ans_except_i, instr_ready_i,
    input  pcgen_ready_o, mem_req_valid_o, mem_req_addr_o, mem_ans_ready_o,
           instr_valid_o, instr_pc_o, instr_o, instr_except_o
  );

endinterface

// File: rtl/fetch_mem_if_ifq.sv
// ----------------------------------------------------------------------------
// fetch_ifq
// Generic in-order queue of T entries, DEPTH a power of 2 (>= 2).
// Each entry carries a side mark bit that can be set on every entry at once.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   i_flush         : empty the queue at the next edge (push/pop ignored)
//   i_mark_all      : set the mark of every stored entry at the next edge
//   i_push, i_data, i_push_mark : write an entry (ignored when full)
//   i_pop           : drop the head entry (ignored when empty)
//   o_head, o_head_mark : head entry and its mark
//   o_cnt, o_empty  : occupancy
// ----------------------------------------------------------------------------
module fetch_ifq #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_flush,
  input  logic                     i_mark_all,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_push_mark,
  input  logic                     i_pop,
  output T                         o_head,
  output logic                     o_head_mark,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  T               r_mem [DEPTH];
  logic [DEPTH-1:0] r_mark;
  logic [AW:0]    r_wr;
  logic [AW:0]    r_rd;
  logic           w_full;
  logic           w_push;
  logic           w_pop;

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_cnt   = r_wr - r_rd;

  assign o_head      = r_mem[r_rd[AW-1:0]];
  assign o_head_mark = r_mark[r_rd[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_mark <= '0;
    end else begin
      if (i_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PTR_ONE;
        if (w_pop)  r_rd <= r_rd + PTR_ONE;
      end
      // Mark-all covers entries present at this edge; a same-edge push keeps
      // its own mark.
      if (i_mark_all) r_mark <= '1;
      if (w_push && !i_flush) r_mark[r_wr[AW-1:0]] <= i_push_mark;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fetch_mem_if.sv
// ----------------------------------------------------------------------------
// fetch_mem_if
// Instruction-memory request/response engine behind the PC generator.
// Accepts one PC per cycle, issues it to memory, tracks in-flight requests,
// discards responses made stale by a flush and buffers the survivors in
// order toward decode.
// Parameters:
//   BUF_DEPTH : in-flight requests + buffered responses (power of 2, >= 2)
//   BOOT_PC   : instr_pc_o value while the output buffer is empty
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : fetch_mem_if_if.master (flush, pcgen, mem req/ans, instr)
// Build option:
//   FETCH_BYPASS_EN : when defined, a live response arriving at an empty
//                     buffer is shown on instr_* in the same cycle and, if
//                     decode takes it, never written to the buffer.
// ----------------------------------------------------------------------------
module fetch_mem_if
  import fetch_mem_if_pkg::*;
#(
  parameter int              BUF_DEPTH = FETCH_BUF_DEPTH,
  parameter logic [XLEN-1:0] BOOT_PC   = 64'h0
) (
  input logic           clk_i,
  input logic           rst_ni,
  fetch_mem_if_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [CW-1:0] w_trk_cnt;
  logic [CW-1:0] w_buf_cnt;
  logic [CW:0]   w_occ;
  logic          w_credit_ok;
  logic          w_req_ok;
  logic          w_req_hs;
  fetch_track_t  w_trk_in;
  fetch_track_t  w_trk_head;
  logic          w_trk_head_mark;
  logic          w_trk_empty;
  logic          w_stale;
  logic          w_ans_live;
  fetch_instr_t  w_ans_entry;
  logic          w_buf_push;
  logic          w_buf_pop;
  fetch_instr_t  w_buf_head;
  logic          w_buf_empty;
  logic          w_unused_buf_mark;
  logic          w_out_valid;
  fetch_instr_t  w_out_entry;

  // Credit uses registered occupancy only, so a same-cycle pop never frees a
  // slot early and the buffer can never overflow.
  assign w_occ       = {1'b0, w_trk_cnt} + {1'b0, w_buf_cnt};
  assign w_credit_ok = w_occ < (CW+1)'(BUF_DEPTH);
  assign w_req_ok    = rst_ni & w_credit_ok & ~bus.flush_i;
  assign w_req_hs    = bus.pcgen_valid_i & bus.mem_req_ready_i & w_req_ok;

  assign bus.mem_req_valid_o = bus.pcgen_valid_i & w_req_ok;
  assign bus.pcgen_ready_o   = bus.mem_req_ready_i & w_req_ok;
  assign bus.mem_req_addr_o  = bus.pcgen_pc_i;
  assign bus.mem_ans_ready_o = 1'b1;

  assign w_trk_in = '{pc: bus.pcgen_pc_i, stale: 1'b0};

  // Tracker: one entry per accepted request; flush marks them all stale.
  fetch_ifq #(
    .T     (fetch_track_t),
    .DEPTH (BUF_DEPTH)
  ) u_trk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_flush     (1'b0),
    .i_mark_all  (bus.flush_i),
    .i_push      (w_req_hs),
    .i_data      (w_trk_in),
    .i_push_mark (1'b0),
    .i_pop       (bus.mem_ans_valid_i),
    .o_head      (w_trk_head),
    .o_head_mark (w_trk_head_mark),
    .o_cnt       (w_trk_cnt),
    .o_empty     (w_trk_empty)
  );

  assign w_stale     = w_trk_head.stale | w_trk_head_mark;
  assign w_ans_live  = bus.mem_ans_valid_i & ~w_trk_empty & ~w_stale & ~bus.flush_i;
  assign w_ans_entry = fetch_make_entry(w_trk_head.pc, bus.mem_ans_data_i,
                                        bus.mem_ans_except_i);

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass   = w_ans_live & w_buf_empty;
  assign w_buf_push = w_ans_live & ~(w_bypass & bus.instr_ready_i);
`else
  assign w_buf_push = w_ans_live;
`endif

  assign w_buf_pop = bus.instr_ready_i & ~w_buf_empty;

  // Output buffer toward decode; flush empties it at the same edge.
  fetch_ifq #(
    .T     (fetch_instr_t),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_flush     (bus.flush_i),
    .i_mark_all  (1'b0),
    .i_push      (w_buf_push),
    .i_data      (w_ans_entry),
    .i_push_mark (1'b0),
    .i_pop       (w_buf_pop),
    .o_head      (w_buf_head),
    .o_head_mark (w_unused_buf_mark),
    .o_cnt       (w_buf_cnt),
    .o_empty     (w_buf_empty)
  );

  always_comb begin
    w_out_valid = 1'b0;
    w_out_entry = fetch_make_entry(BOOT_PC, '0, 1'b0);
    if (!w_buf_empty) begin
      w_out_valid = 1'b1;
      w_out_entry = w_buf_head;
    end
`ifdef FETCH_BYPASS_EN
    else if (w_bypass) begin
      w_out_valid = 1'b1;
      w_out_entry = w_ans_entry;
    end
`endif
  end

  assign bus.instr_valid_o  = w_out_valid;
  assign bus.instr_pc_o     = w_out_entry.pc;
  assign bus.instr_o        = w_out_entry.instr;
  assign bus.instr_except_o = w_out_entry.except;

  // A response with nothing in flight breaks the memory protocol.
  a_ans_has_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   bus.mem_ans_valid_i |-> !w_trk_empty);

endmodule

// File: tb/tb_fetch_mem_if.sv
module tb_fetch_mem_if;
  import fetch_mem_if_pkg::*;

  localparam logic [XLEN-1:0] BOOT = 64'h0000_0000_8000_0000;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  fetch_mem_if_if bus();

  fetch_mem_if #(.BUF_DEPTH(4), .BOOT_PC(BOOT)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    int              due;
    logic [XLEN-1:0] pc;
  } mreq_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           mem_lat = 2;
  mreq_t        mq[$];
  mreq_t        mr;
  fetch_instr_t exp_q[$];
  fetch_instr_t mon_act;
  fetch_instr_t mon_exp;

  function automatic logic [ILEN-1:0] mdata(input logic [XLEN-1:0] pc);
    return 32'hC0DE_0000 ^ pc[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [XLEN-1:0] pc, input logic ex);
    exp_q.push_back('{pc: pc, instr: mdata(pc), except: ex});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d entries still pending after %0d cycles, want 0",
               name, exp_q.size(), maxc);
      exp_q.delete();
    end
  endtask

  // Memory model: in-order responses mem_lat cycles after acceptance.
  always @(negedge clk_i) begin
    if (rst_ni && bus.mem_req_valid_o && bus.mem_req_ready_i)
      mq.push_back('{due: cyc + mem_lat, pc: bus.mem_req_addr_o});
  end

  initial begin
    bus.mem_ans_valid_i  = 1'b0;
    bus.mem_ans_data_i   = '0;
    bus.mem_ans_except_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mr = mq.pop_front();
        bus.mem_ans_valid_i  = 1'b1;
        bus.mem_ans_data_i   = mdata(mr.pc);
        bus.mem_ans_except_i = (mr.pc == 64'h40);
      end else begin
        bus.mem_ans_valid_i  = 1'b0;
        bus.mem_ans_data_i   = '0;
        bus.mem_ans_except_i = 1'b0;
      end
    end
  end

  // Monitor: every entry decode consumes is checked against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && bus.instr_valid_o && bus.instr_ready_i) begin
      mon_act.pc     = bus.instr_pc_o;
      mon_act.instr  = bus.instr_o;
      mon_act.except = bus.instr_except_o;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got pc=%h instr=%h exc=%b want no entry",
                 mon_act.pc, mon_act.instr, mon_act.except);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL out_entry: got pc=%h instr=%h exc=%b want pc=%h instr=%h exc=%b",
                   mon_act.pc, mon_act.instr, mon_act.except,
                   mon_exp.pc, mon_exp.instr, mon_exp.except);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nxt;
    logic [XLEN-1:0] bpcs [3];
    logic [XLEN-1:0] fpcs [3];
    int acc;

    bpcs = '{64'h0, 64'h4, 64'h8};
    fpcs = '{64'h10, 64'h14, 64'h18};

    bus.flush_i         = 1'b0;
    bus.pcgen_valid_i   = 1'b1;
    bus.pcgen_pc_i      = 64'h999;
    bus.mem_req_ready_i = 1'b1;
    bus.instr_ready_i   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_instr_valid", bus.instr_valid_o, 0);
    check("rst_instr_pc", bus.instr_pc_o, BOOT);
    check("rst_instr", bus.instr_o, 0);
    check("rst_instr_except", bus.instr_except_o, 0);
    check("rst_mem_req_valid", bus.mem_req_valid_o, 0);
    bus.pcgen_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();

    // Basic fetch, memory latency 2
    mem_lat = 2;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pcgen_valid_i = 1'b1;
      bus.pcgen_pc_i    = bpcs[i];
      @(negedge clk_i);
      check("basic_ready", bus.pcgen_ready_o, 1);
      if (bus.pcgen_ready_o) exp_push(bpcs[i], 1'b0);
      step();
    end
    bus.pcgen_valid_i = 1'b0;
    drain("basic_drain", 20);
    repeat (3) step();

    // Backpressure, memory latency 1, decode stalled
    mem_lat = 1;
    bus.instr_ready_i = 1'b0;
    pc  = 64'h0;
    acc = 0;
    bus.pcgen_valid_i = 1'b1;
    repeat (10) begin
      bus.pcgen_pc_i = pc;
      nxt = pc;
      @(negedge clk_i);
      if (bus.pcgen_ready_o) begin
        exp_push(pc, 1'b0);
        acc++;
        nxt = pc + 64'h4;
      end
      step();
      pc = nxt;
    end
    check("bp_accepted", acc, 4);
    @(negedge clk_i);
    check("bp_ready_low", bus.pcgen_ready_o, 0);
    bus.pcgen_valid_i = 1'b0;
    step();
    bus.instr_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_ready_low_during_pop", bus.pcgen_ready_o, 0);
    step();
    bus.instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("bp_ready_back", bus.pcgen_ready_o, 1);
    step();
    bus.instr_ready_i = 1'b1;
    drain("bp_drain", 20);
    repeat (3) step();

    // Flush with three requests in flight
    mem_lat = 4;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pcgen_valid_i = 1'b1;
      bus.pcgen_pc_i    = fpcs[i];
      step();
    end
    bus.flush_i    = 1'b1;
    bus.pcgen_pc_i = 64'h100;
    @(negedge clk_i);
    check("flush_no_req_valid", bus.mem_req_valid_o, 0);
    check("flush_no_ready", bus.pcgen_ready_o, 0);
    step();
    bus.flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_new_ready", bus.pcgen_ready_o, 1);
    if (bus.pcgen_ready_o) exp_push(64'h100, 1'b0);
    step();
    bus.pcgen_valid_i = 1'b0;
    drain("flush_drain", 30);
    repeat (3) step();

    // Flush in the same cycle as the response for 0x20
    mem_lat = 2;
    bus.pcgen_valid_i = 1'b1;
    bus.pcgen_pc_i    = 64'h20;
    step();
    bus.pcgen_valid_i = 1'b0;
    step();
    bus.flush_i = 1'b1;
    @(negedge clk_i);
    check("coinc_no_output", bus.instr_valid_o, 0);
    step();
    bus.flush_i = 1'b0;
    @(negedge clk_i);
    check("coinc_buf_empty", bus.instr_valid_o, 0);
    repeat (4) step();

    // Access fault on 0x40
    mem_lat = 2;
    bus.pcgen_valid_i = 1'b1;
    bus.pcgen_pc_i    = 64'h40;
    exp_push(64'h40, 1'b1);
    step();
    bus.pcgen_valid_i = 1'b0;
    step();
    @(negedge clk_i);
`ifdef FETCH_BYPASS_EN
    check("fault_resp_cycle_valid", bus.instr_valid_o, 1);
    check("fault_resp_cycle_pc", bus.instr_pc_o, 64'h40);
`else
    check("fault_resp_cycle_valid", bus.instr_valid_o, 0);
`endif
    step();
    @(negedge clk_i);
`ifdef FETCH_BYPASS_EN
    check("fault_next_valid", bus.instr_valid_o, 0);
`else
    check("fault_next_valid", bus.instr_valid_o, 1);
    check("fault_next_pc", bus.instr_pc_o, 64'h40);
    check("fault_next_except", bus.instr_except_o, 1);
`endif
    drain("fault_drain", 10);
    repeat (3) step();

`ifdef FETCH_BYPASS_EN
    // Same-cycle bypass into an empty buffer
    mem_lat = 2;
    bus.pcgen_valid_i = 1'b1;
    bus.pcgen_pc_i    = 64'h8;
    exp_push(64'h8, 1'b0);
    step();
    bus.pcgen_valid_i = 1'b0;
    step();
    @(negedge clk_i);
    check("byp_valid", bus.instr_valid_o, 1);
    check("byp_pc", bus.instr_pc_o, 64'h8);
    check("byp_instr", bus.instr_o, mdata(64'h8));
    step();
    @(negedge clk_i);
    check("byp_not_buffered", bus.instr_valid_o, 0);
    drain("byp_drain", 10);
    repeat (3) step();
`endif

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
